traffic_timer_ctrl: RTL and testbench
=====================================

// Module: traffic_timer_ctrl
// PURPOSE
//   Interval timer and car-sensor conditioner that sequences the traffic-light fsm.
//   Restarts on the fsm's ST (start timer) pulse and returns TS (short) / TL (long) expiry.
//   Converts the raw side-road detector into a clean, synchronized, debounced C.
//   Sits beside fsm in the top level: ST in; TS, TL, C out.
// PARAMETERS
//   PRESCALE     1000  Clk cycles per timer tick (>=1)
//   SHORT_TICKS  5     ticks until TS asserts (>=1, < LONG_TICKS)
//   LONG_TICKS   25    ticks until TL asserts (< 2**CNT_W)
//   DEB_CYCLES   4     stable cycles needed before C changes (>=1)
//   CNT_W        8     width of tick counter / tick_cnt output
// PORTS
//   Clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-low reset
//   ST        in   1      start timer from fsm; synchronous restart while high
//   hold      in   1      maintenance freeze; timer counters hold while high
//   car_raw   in   1      raw car detector, asynchronous to Clk, may bounce
//   TS        out  1      short interval expired (registered)
//   TL        out  1      long interval expired (registered)
//   C         out  1      debounced car present (registered)
//   tick_cnt  out  CNT_W  current tick count, for debug/bench
// BEHAVIOUR
//   Reset (reset=0): asynchronous. pre_cnt=0, tick_cnt=0, state=RUN, TS=TL=0.
//     sync flops=0, deb_cnt=0, C=0. Counting starts on the first edge after release.
//   Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps to 0.
//     tick = (pre_cnt==PRESCALE-1) && !hold.
//     PRESCALE=1 gives tick on every non-hold cycle. Width is $clog2(PRESCALE), minimum 1.
//   Tick counter: increments on tick and saturates at LONG_TICKS. No wrap.
//   State machine (TS/TL driven directly from state registers):
//     RUN   TS=0 TL=0; -> SHORT on the edge where tick_cnt becomes SHORT_TICKS
//     SHORT TS=1 TL=0; -> LONG on the edge where tick_cnt becomes LONG_TICKS
//     LONG  TS=1 TL=1; holds until ST or reset
//   Timing: TS rises exactly SHORT_TICKS*PRESCALE non-hold cycles after the last edge
//     that sampled ST=1. TL rises exactly LONG_TICKS*PRESCALE such cycles after that edge.
//   ST=1 at an edge, from any state:
//     pre_cnt=0, tick_cnt=0, state=RUN, so TS/TL=0 after that edge.
//     Held ST keeps all of these cleared. Counting resumes on the first edge with ST=0.
//   hold=1: pre_cnt, tick_cnt and state are frozen; TS/TL keep their values.
//   ST and hold both high: ST wins; counters clear and stay 0 until hold drops.
//   Car path:
//     car_raw -> 2-flop synchronizer -> car_s.
//     deb_cnt clears whenever car_s==C. Otherwise it increments; when it reaches
//       DEB_CYCLES, C<=car_s and deb_cnt<=0.
//     Clean raw edge to C latency = 2+DEB_CYCLES cycles.
//     Pulses shorter than DEB_CYCLES cycles never reach C.
//     The car path is independent of ST and hold.
//   Reset mid-operation: all outputs go to 0 immediately, with no wait for Clk.
// TESTING  (PRESCALE=4, SHORT_TICKS=2, LONG_TICKS=5, DEB_CYCLES=3)
//   Release reset, ST=0 -> TS rises at edge 8 after release, TL at edge 20;
//     tick_cnt stays at 5.
//   In LONG, 1-cycle ST pulse -> TS=TL=0 after that edge; TS re-rises 8 cycles later,
//     TL 20 cycles later.
//   hold=1 for 10 cycles during RUN -> TS rise delayed by exactly 10 cycles;
//     TS/TL/tick_cnt unchanged during hold.
//   ST=1 and hold=1 together for 6 cycles -> tick_cnt=0, TS=0 throughout;
//     TS rises 8 cycles after both drop.
//   car_raw high for 2 cycles -> C stays 0. car_raw high for 10 cycles -> C rises 5 cycles
//     after the raw edge, falls 5 cycles after the raw fall.
//   Assert reset in LONG with C=1 -> TS=TL=C=0 at once, before any Clk edge;
//     after release the first bench case timing repeats.

Source files
------------

// File: rtl/traffic_timer_ctrl_if.sv
// Signal bundle between the traffic-light fsm and its interval timer / car conditioner.
interface traffic_timer_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             ST;        // start timer, synchronous restart while high
    logic             hold;      // maintenance freeze for the timer counters
    logic             car_raw;   // raw side-road detector, asynchronous, may bounce
    logic             TS;        // short interval expired
    logic             TL;        // long interval expired
    logic             C;         // debounced car present
    logic [CNT_W-1:0] tick_cnt;  // current tick count

    // fsm side: issues ST/hold, owns the detector input, consumes expiry and C
    modport master (
        output ST,
        output hold,
        output car_raw,
        input  TS,
        input  TL,
        input  C,
        input  tick_cnt
    );

    // timer side
    modport slave (
        input  ST,
        input  hold,
        input  car_raw,
        output TS,
        output TL,
        output C,
        output tick_cnt
    );
endinterface

// File: rtl/traffic_timer_ctrl.sv
// Interval timer (TS/TL expiry after ST restart) and car-sensor synchronizer/debouncer
// for the traffic-light fsm.
module traffic_timer_ctrl #(
    parameter int unsigned PRESCALE    = 1000,
    parameter int unsigned SHORT_TICKS = 5,
    parameter int unsigned LONG_TICKS  = 25,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input logic                  Clk,
    input logic                  reset,
    traffic_timer_ctrl_if.slave  bus
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] SHORT_CNT = CNT_W'(SHORT_TICKS);
    localparam logic [CNT_W-1:0] LONG_CNT  = CNT_W'(LONG_TICKS);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES);

    // Encoding chosen so TS is bit 0 and TL is bit 1 of the state register.
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SHORT = 2'b01,
        LONG  = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] pre_cnt_q;
    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_inc;
    logic             tick;

    logic             sync1_q;
    logic             car_s;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_inc;
    logic             c_q;

    // Prescaler tick and incremented tick count used by the counters and fsm.
    always_comb begin
        tick         = 1'b0;
        tick_cnt_inc = tick_cnt_q + CNT_W'(1);
        if ((pre_cnt_q == PRE_LAST) && !bus.hold) begin
            tick = 1'b1;
        end
    end

    // Prescaler: ST clears, hold freezes, otherwise counts 0..PRESCALE-1 and wraps.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            pre_cnt_q <= '0;
        end else if (bus.ST) begin
            pre_cnt_q <= '0;
        end else if (!bus.hold) begin
            if (pre_cnt_q == PRE_LAST) begin
                pre_cnt_q <= '0;
            end else begin
                pre_cnt_q <= pre_cnt_q + PRE_W'(1);
            end
        end
    end

    // Tick counter: ST clears, increments on tick, saturates at LONG_TICKS.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
        end else if (bus.ST) begin
            tick_cnt_q <= '0;
        end else if (tick && (tick_cnt_q != LONG_CNT)) begin
            tick_cnt_q <= tick_cnt_inc;
        end
    end

    // Interval fsm state register.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Interval fsm next state: advance on the tick that lands the count on a threshold.
    always_comb begin
        state_d = state_q;
        if (bus.ST) begin
            state_d = RUN;
        end else if (tick) begin
            case (state_q)
                RUN: begin
                    if (tick_cnt_inc == SHORT_CNT) begin
                        state_d = SHORT;
                    end
                end
                SHORT: begin
                    if (tick_cnt_inc == LONG_CNT) begin
                        state_d = LONG;
                    end
                end
                LONG: begin
                    state_d = LONG;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous detector.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            car_s   <= 1'b0;
        end else begin
            sync1_q <= bus.car_raw;
            car_s   <= sync1_q;
        end
    end

    assign deb_cnt_inc = deb_cnt_q + DEB_W'(1);

    // Debouncer: C follows car_s only after DEB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            deb_cnt_q <= '0;
            c_q       <= 1'b0;
        end else if (car_s == c_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_inc == DEB_LAST) begin
            deb_cnt_q <= '0;
            c_q       <= car_s;
        end else begin
            deb_cnt_q <= deb_cnt_inc;
        end
    end

    assign bus.TS       = state_q[0];
    assign bus.TL       = state_q[1];
    assign bus.C        = c_q;
    assign bus.tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_traffic_timer_ctrl.sv
// Directed bench for traffic_timer_ctrl with PRESCALE=4, SHORT=2, LONG=5, DEB=3.
module tb_traffic_timer_ctrl;

    localparam int unsigned CNT_W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    traffic_timer_ctrl_if #(.CNT_W(CNT_W)) bus ();

    traffic_timer_ctrl #(
        .PRESCALE    (4),
        .SHORT_TICKS (2),
        .LONG_TICKS  (5),
        .DEB_CYCLES  (3),
        .CNT_W       (CNT_W)
    ) dut (
        .Clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    // Timer sequence from a fresh start at edge 0: TS at edge 8, TL at edge 20.
    task automatic run_from_start(input string tag);
        step(7);
        chk({tag, "_ts_e7"}, 32'(bus.TS), 32'd0);
        chk({tag, "_cnt_e7"}, 32'(bus.tick_cnt), 32'd1);
        step(1);
        chk({tag, "_ts_e8"}, 32'(bus.TS), 32'd1);
        chk({tag, "_cnt_e8"}, 32'(bus.tick_cnt), 32'd2);
        chk({tag, "_tl_e8"}, 32'(bus.TL), 32'd0);
        step(11);
        chk({tag, "_tl_e19"}, 32'(bus.TL), 32'd0);
        chk({tag, "_cnt_e19"}, 32'(bus.tick_cnt), 32'd4);
        step(1);
        chk({tag, "_tl_e20"}, 32'(bus.TL), 32'd1);
        chk({tag, "_ts_e20"}, 32'(bus.TS), 32'd1);
        chk({tag, "_cnt_e20"}, 32'(bus.tick_cnt), 32'd5);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.ST      = 1'b0;
        bus.hold    = 1'b0;
        bus.car_raw = 1'b0;

        // Reset state
        step(3);
        chk("rst_ts", 32'(bus.TS), 32'd0);
        chk("rst_tl", 32'(bus.TL), 32'd0);
        chk("rst_c", 32'(bus.C), 32'd0);
        chk("rst_cnt", 32'(bus.tick_cnt), 32'd0);
        rst_n = 1'b1;

        // Free run after release, then saturation
        run_from_start("free");
        step(10);
        chk("sat_cnt", 32'(bus.tick_cnt), 32'd5);
        chk("sat_tl", 32'(bus.TL), 32'd1);

        // One-cycle ST in LONG restarts everything
        bus.ST = 1'b1;
        step(1);
        bus.ST = 1'b0;
        chk("st_ts", 32'(bus.TS), 32'd0);
        chk("st_tl", 32'(bus.TL), 32'd0);
        chk("st_cnt", 32'(bus.tick_cnt), 32'd0);
        run_from_start("restart");

        // hold for 10 cycles during RUN delays TS by exactly 10 cycles
        bus.ST = 1'b1;
        step(1);
        bus.ST = 1'b0;
        step(5);
        chk("pre_hold_cnt", 32'(bus.tick_cnt), 32'd1);
        bus.hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("hold_cnt", 32'(bus.tick_cnt), 32'd1);
            chk("hold_ts", 32'(bus.TS), 32'd0);
        end
        bus.hold = 1'b0;
        step(2);
        chk("hold_ts_late", 32'(bus.TS), 32'd0);
        step(1);
        chk("hold_ts_rise", 32'(bus.TS), 32'd1);
        chk("hold_cnt_rise", 32'(bus.tick_cnt), 32'd2);

        // hold in SHORT keeps TS and count
        bus.hold = 1'b1;
        step(20);
        chk("hold_short_ts", 32'(bus.TS), 32'd1);
        chk("hold_short_tl", 32'(bus.TL), 32'd0);
        chk("hold_short_cnt", 32'(bus.tick_cnt), 32'd2);

        // ST and hold together: ST wins, counters stay cleared
        bus.ST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("sth_cnt", 32'(bus.tick_cnt), 32'd0);
            chk("sth_ts", 32'(bus.TS), 32'd0);
        end
        bus.ST   = 1'b0;
        bus.hold = 1'b0;
        step(7);
        chk("sth_ts_e7", 32'(bus.TS), 32'd0);
        step(1);
        chk("sth_ts_e8", 32'(bus.TS), 32'd1);

        // Car: 2-cycle glitch is filtered
        bus.car_raw = 1'b1;
        step(2);
        bus.car_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("glitch_c", 32'(bus.C), 32'd0);
        end

        // Car: 10-cycle pulse, rise and fall each 5 cycles after the raw edge
        bus.car_raw = 1'b1;
        step(4);
        chk("car_rise_e4", 32'(bus.C), 32'd0);
        step(1);
        chk("car_rise_e5", 32'(bus.C), 32'd1);
        step(5);
        bus.car_raw = 1'b0;
        step(4);
        chk("car_fall_e4", 32'(bus.C), 32'd1);
        step(1);
        chk("car_fall_e5", 32'(bus.C), 32'd0);

        // Reset asserted in LONG with C=1 clears outputs without a clock edge
        bus.ST = 1'b1;
        step(1);
        bus.ST      = 1'b0;
        bus.car_raw = 1'b1;
        step(20);
        chk("pre_rst_tl", 32'(bus.TL), 32'd1);
        chk("pre_rst_c", 32'(bus.C), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ts", 32'(bus.TS), 32'd0);
        chk("async_tl", 32'(bus.TL), 32'd0);
        chk("async_c", 32'(bus.C), 32'd0);
        chk("async_cnt", 32'(bus.tick_cnt), 32'd0);
        bus.car_raw = 1'b0;
        step(2);
        rst_n = 1'b1;
        run_from_start("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
